// File: rtl/multicycle_ctrl_fsm_if.sv
// Control interface between the multicycle RV32I controller and its datapath.
// The slave modport is the controller's view; the master modport is the datapath's view.
interface multicycle_ctrl_fsm_if #(
    parameter int CNT_W = 32
);
    // Inputs to the controller
    logic [6:0]       opcode;
    logic             mem_ready;

    // Datapath enables
    logic             pc_write;
    logic             branch;
    logic             adr_src;
    logic             mem_write;
    logic             ir_write;
    logic             reg_write;

    // Mux selects and ALU control
    logic [1:0]       result_src;
    logic [1:0]       alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       alu_op;
    logic [1:0]       imm_src;

    // Status
    logic             illegal;
    logic             instr_retired;
    logic [CNT_W-1:0] retire_count;
    logic [3:0]       state;

    modport slave (
        input  opcode, mem_ready,
        output pc_write, branch, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal, instr_retired, retire_count, state
    );

    modport master (
        output opcode, mem_ready,
        input  pc_write, branch, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op, imm_src,
               illegal, instr_retired, retire_count, state
    );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// Moore control FSM for a shared multicycle RV32I datapath (lw, sw, R, I-ALU, beq/bne, jal).
// Optional feature: define MC_FSM_STALL_EN to make FETCH/MEMRD/MEMWR wait on mem_ready;
// without it memory is single-cycle and mem_ready is ignored.
module multicycle_ctrl_fsm #(
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    multicycle_ctrl_fsm_if.slave bus
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECR   = 4'd6,
        EXECI   = 4'd7,
        ALUWB   = 4'd8,
        BEQ     = 4'd9,
        JAL     = 4'd10,
        ILLEGAL = 4'd11
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] retire_count_q, retire_count_d;
    logic             mem_ready;

    logic       pc_write, branch, adr_src, mem_write, ir_write, reg_write;
    logic       illegal, instr_retired;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;

`ifdef MC_FSM_STALL_EN
    assign mem_ready = bus.mem_ready;
`else
    // Single-cycle memory: the handshake input has no effect.
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign mem_ready        = 1'b1;
`endif

    // State and retire counter registers.
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= FETCH;
            retire_count_q <= '0;
        end else begin
            state_q        <= state_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Next-state and Moore outputs decoded from the registered state.
    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        branch        = 1'b0;
        adr_src       = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        result_src    = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        illegal       = 1'b0;
        instr_retired = 1'b0;

        case (state_q)
            FETCH: begin
                // PC + 4 computed on the ALU and written back straight from ALUResult.
                adr_src    = 1'b0;
                alu_src_a  = 2'b00;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // Precompute OldPC + Imm as the branch/jump target.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECR;
                    OP_I:         state_d = EXECI;
                    OP_BR:        state_d = BEQ;
                    OP_JAL:       state_d = JAL;
                    default:      state_d = ILLEGAL;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b00;
                state_d   = (bus.opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                adr_src = 1'b1;
                if (mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                // Write enable is held for the whole access; retire only when it completes.
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    instr_retired = 1'b1;
                    state_d       = FETCH;
                end
            end
            EXECR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b00;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = ALUWB;
            end
            ALUWB: begin
                result_src    = 2'b00;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            BEQ: begin
                // Compare rs1/rs2; the PC load is qualified outside by the ALU flags.
                alu_src_a     = 2'b10;
                alu_src_b     = 2'b00;
                alu_op        = 2'b01;
                result_src    = 2'b00;
                branch        = 1'b1;
                instr_retired = 1'b1;
                state_d       = FETCH;
            end
            JAL: begin
                // Jump to the target held in ALUOut while computing OldPC + 4 for rd.
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                result_src = 2'b00;
                pc_write   = 1'b1;
                state_d    = ALUWB;
            end
            ILLEGAL: begin
                illegal = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset masks every enable and pulse so nothing is written while held in reset.
        if (rst) begin
            pc_write      = 1'b0;
            branch        = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            reg_write     = 1'b0;
            illegal       = 1'b0;
            instr_retired = 1'b0;
        end

        retire_count_d = retire_count_q + CNT_W'(instr_retired);
    end

    // Immediate format select, the only output taken directly from the opcode.
    always_comb begin
        case (bus.opcode)
            OP_LW, OP_I: imm_src = 2'b00;
            OP_SW:       imm_src = 2'b01;
            OP_BR:       imm_src = 2'b10;
            OP_JAL:      imm_src = 2'b11;
            default:     imm_src = 2'b00;
        endcase
    end

    assign bus.pc_write      = pc_write;
    assign bus.branch        = branch;
    assign bus.adr_src       = adr_src;
    assign bus.mem_write     = mem_write;
    assign bus.ir_write      = ir_write;
    assign bus.reg_write     = reg_write;
    assign bus.result_src    = result_src;
    assign bus.alu_src_a     = alu_src_a;
    assign bus.alu_src_b     = alu_src_b;
    assign bus.alu_op        = alu_op;
    assign bus.imm_src       = imm_src;
    assign bus.illegal       = illegal;
    assign bus.instr_retired = instr_retired;
    assign bus.retire_count  = retire_count_q;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm. Stall checks run when MC_FSM_STALL_EN is defined.
module tb_multicycle_ctrl_fsm;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    localparam logic [31:0] S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3,
                            S_MEMWB = 4, S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7,
                            S_ALUWB = 8, S_BEQ = 9, S_JAL = 10, S_ILLEGAL = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst2 = 1'b1;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if #(.CNT_W(32)) bus ();
    multicycle_ctrl_fsm_if #(.CNT_W(2))  bus2 ();

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Narrow counter instance used to exercise wrap-around.
    multicycle_ctrl_fsm #(.CNT_W(2)) dut_w (
        .clk (clk),
        .rst (rst2),
        .bus (bus2.slave)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wr_cycles;
        int ret_pulses;

        bus.opcode     = OP_LW;
        bus.mem_ready  = 1'b1;
        bus2.opcode    = OP_BR;
        bus2.mem_ready = 1'b1;

        // 1. Reset held two cycles: FETCH, enables masked, counter clear.
        tick();
        tick();
        check("rst_state",     32'(bus.state), S_FETCH);
        check("rst_pc_write",  32'(bus.pc_write), 0);
        check("rst_ir_write",  32'(bus.ir_write), 0);
        check("rst_count",     bus.retire_count, 0);
        rst = 1'b0;
        #1;
        check("f_ir_write",    32'(bus.ir_write), 1);
        check("f_pc_write",    32'(bus.pc_write), 1);
        check("f_alu_src_b",   32'(bus.alu_src_b), 2);
        check("f_result_src",  32'(bus.result_src), 2);

        // 2. lw: FETCH, DECODE, MEMADR, MEMRD, MEMWB.
        check("lw_imm_src",    32'(bus.imm_src), 0);
        tick();
        check("lw_s_decode",   32'(bus.state), S_DECODE);
        check("dec_alu_src_a", 32'(bus.alu_src_a), 1);
        check("dec_alu_src_b", 32'(bus.alu_src_b), 1);
        tick();
        check("lw_s_memadr",   32'(bus.state), S_MEMADR);
        check("ma_alu_src_a",  32'(bus.alu_src_a), 2);
        tick();
        check("lw_s_memrd",    32'(bus.state), S_MEMRD);
        check("mr_adr_src",    32'(bus.adr_src), 1);
        check("mr_reg_write",  32'(bus.reg_write), 0);
        tick();
        check("lw_s_memwb",    32'(bus.state), S_MEMWB);
        check("wb_reg_write",  32'(bus.reg_write), 1);
        check("wb_result_src", 32'(bus.result_src), 1);
        check("wb_retired",    32'(bus.instr_retired), 1);
        check("wb_count_pre",  bus.retire_count, 0);
        tick();
        check("lw_back_fetch", 32'(bus.state), S_FETCH);
        check("lw_count",      bus.retire_count, 1);

        // 3. sw then beq back to back.
        bus.opcode = OP_SW;
        #1;
        check("sw_imm_src",    32'(bus.imm_src), 1);
        tick();
        tick();
        check("sw_no_wr_yet",  32'(bus.mem_write), 0);
        tick();
        check("sw_s_memwr",    32'(bus.state), S_MEMWR);
        check("sw_mem_write",  32'(bus.mem_write), 1);
        check("sw_retired",    32'(bus.instr_retired), 1);
        bus.opcode = OP_BR;
        tick();
        check("sw_wr_off",     32'(bus.mem_write), 0);
        check("sw_count",      bus.retire_count, 2);
        check("br_imm_src",    32'(bus.imm_src), 2);
        tick();
        check("br_no_branch",  32'(bus.branch), 0);
        tick();
        check("br_s_beq",      32'(bus.state), S_BEQ);
        check("br_branch",     32'(bus.branch), 1);
        check("br_alu_op",     32'(bus.alu_op), 1);
        tick();
        check("br_branch_off", 32'(bus.branch), 0);
        check("br_count",      bus.retire_count, 3);

        // R-type and I-type ALU.
        bus.opcode = OP_R;
        tick();
        tick();
        check("r_s_execr",     32'(bus.state), S_EXECR);
        check("r_alu_op",      32'(bus.alu_op), 2);
        check("r_alu_src_b",   32'(bus.alu_src_b), 0);
        tick();
        check("r_s_aluwb",     32'(bus.state), S_ALUWB);
        check("r_reg_write",   32'(bus.reg_write), 1);
        tick();
        check("r_count",       bus.retire_count, 4);
        bus.opcode = OP_I;
        tick();
        tick();
        check("i_s_execi",     32'(bus.state), S_EXECI);
        check("i_alu_src_b",   32'(bus.alu_src_b), 1);
        tick();
        tick();
        check("i_count",       bus.retire_count, 5);

        // 4. jal.
        bus.opcode = OP_JAL;
        #1;
        check("jal_imm_src",   32'(bus.imm_src), 3);
        tick();
        tick();
        check("jal_s_jal",     32'(bus.state), S_JAL);
        check("jal_pc_write",  32'(bus.pc_write), 1);
        check("jal_no_retire", 32'(bus.instr_retired), 0);
        tick();
        check("jal_s_aluwb",   32'(bus.state), S_ALUWB);
        check("jal_reg_write", 32'(bus.reg_write), 1);
        check("jal_res_src",   32'(bus.result_src), 0);
        tick();
        check("jal_count",     bus.retire_count, 6);

        // 5. Illegal opcode.
        bus.opcode = OP_BAD;
        #1;
        check("bad_imm_src",   32'(bus.imm_src), 0);
        tick();
        tick();
        check("bad_s_illegal", 32'(bus.state), S_ILLEGAL);
        check("bad_illegal",   32'(bus.illegal), 1);
        check("bad_writes",    32'({bus.pc_write, bus.reg_write, bus.mem_write, bus.instr_retired}), 0);
        tick();
        check("bad_back",      32'(bus.state), S_FETCH);
        check("bad_pulse_off", 32'(bus.illegal), 0);
        check("bad_count",     bus.retire_count, 6);

        // 6a. Reset asserted mid-MEMADR takes effect without a clock.
        bus.opcode = OP_LW;
        tick();
        tick();
        check("mid_s_memadr",  32'(bus.state), S_MEMADR);
        rst = 1'b1;
        #1;
        check("mid_rst_state", 32'(bus.state), S_FETCH);
        check("mid_rst_count", bus.retire_count, 0);
        check("mid_rst_ir",    32'(bus.ir_write), 0);
        tick();
        rst = 1'b0;
        #1;

`ifdef MC_FSM_STALL_EN
        // 6b. Stalls: FETCH waits on mem_ready, MEMWR holds mem_write for 4 cycles.
        bus.opcode    = OP_SW;
        bus.mem_ready = 1'b0;
        #1;
        check("st_f_ir_write", 32'(bus.ir_write), 0);
        check("st_f_pc_write", 32'(bus.pc_write), 0);
        tick();
        check("st_f_hold",     32'(bus.state), S_FETCH);
        bus.mem_ready = 1'b1;
        #1;
        check("st_f_ir_go",    32'(bus.ir_write), 1);
        tick();
        tick();
        tick();
        check("st_s_memwr",    32'(bus.state), S_MEMWR);
        wr_cycles  = 0;
        ret_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_ready = (i == 3);
            #1;
            if (bus.mem_write) wr_cycles++;
            if (bus.instr_retired) ret_pulses++;
            tick();
        end
        bus.mem_ready = 1'b1;
        check("st_wr_cycles",  32'(wr_cycles), 4);
        check("st_ret_pulses", 32'(ret_pulses), 1);
        check("st_back_fetch", 32'(bus.state), S_FETCH);
        check("st_count",      bus.retire_count, 1);
`else
        // 6b. mem_ready is ignored: FETCH and MEMWR advance regardless.
        bus.opcode    = OP_SW;
        bus.mem_ready = 1'b0;
        #1;
        check("ns_f_ir_write", 32'(bus.ir_write), 1);
        wr_cycles  = 0;
        ret_pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.mem_write) wr_cycles++;
            if (bus.instr_retired) ret_pulses++;
            tick();
        end
        bus.mem_ready = 1'b1;
        check("ns_wr_cycles",  32'(wr_cycles), 1);
        check("ns_ret_pulses", 32'(ret_pulses), 1);
        check("ns_back_fetch", 32'(bus.state), S_FETCH);
        check("ns_count",      bus.retire_count, 1);
`endif

        // 6c. Counter wrap on a 2-bit instance: three beq reach 3, the fourth wraps to 0.
        rst2 = 1'b0;
        #1;
        for (int i = 0; i < 9; i++) tick();
        check("wrap_all_ones", 32'(bus2.retire_count), 3);
        check("wrap_state",    32'(bus2.state), S_FETCH);
        for (int i = 0; i < 3; i++) tick();
        check("wrap_zero",     32'(bus2.retire_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
